mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, words of 32-bit storage.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted before completion (legal 0..7).
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port GlobalReset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Read  input  1  read request from datapath (level).
REQ-006 SHALL have port write  input  1  write request from datapath (level).
REQ-007 SHALL have port Address  input  32  word address, taken from MAR.
REQ-008 SHALL have port MemDataIn  input  32  write data, taken from MDR.
REQ-009 SHALL have port Mdatain  output  32  read data, fed to the datapath MDR input.
REQ-010 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port Busy  output  1  high whenever the responder is not IDLE.
REQ-012 SHALL have port Error  output  1  one-cycle pulse with Ready on a rejected access.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE and HOLD.
REQ-014 In IDLE, Read or write sampled high at rising edge E0 SHALL accept a request, latch Address, MemDataIn and the request type, and load the wait counter with LATENCY.
REQ-015 Transition out of IDLE SHALL be to WAIT when LATENCY>0, otherwise to DONE.
REQ-016 In WAIT, the counter SHALL decrement each edge, and the state SHALL move to DONE on the edge where the counter reaches 0.
REQ-017 The responder SHALL enter DONE at edge E0+LATENCY+1, and Ready SHALL be high for exactly that one cycle.
REQ-018 A write SHALL update mem[latched address] at the edge entering DONE.
REQ-019 A read SHALL load Mdatain from mem[latched address] at the edge entering DONE, and Mdatain SHALL hold that value until the next completed read.
REQ-020 From DONE, the state SHALL go to IDLE if Read and write are both low, otherwise to HOLD.
REQ-021 HOLD SHALL return to IDLE only after Read and write are both low, so that a held request is never serviced twice.
REQ-022 Read and write both high at acceptance SHALL complete with the normal latency with Error=1 and Ready=1, with no memory change and Mdatain unchanged.
REQ-023 Address>=DEPTH SHALL complete with the normal latency with Error=1 and Ready=1, with the write dropped or Mdatain forced to 0 for a read.
REQ-024 Busy SHALL equal (state != IDLE).
REQ-025 Inputs SHALL be ignored outside IDLE, and a new request SHALL be sampled only in IDLE.
REQ-026 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-027 GlobalReset low SHALL immediately force the state to IDLE, the counter to 0, Ready=0, Error=0, Busy=0 and Mdatain=0.
REQ-028 Reset asserted mid-operation SHALL abort the access, and a pending write SHALL NOT be committed.
REQ-029 The first request SHALL be accepted on the first rising edge after GlobalReset is released high.

Configuration
REQ-030 Macro WAIT_STATES_EN defined SHALL give WAIT-state and counter behaviour per the LATENCY parameter.
REQ-031 Macro WAIT_STATES_EN undefined SHALL omit the WAIT state and counter, ignore LATENCY, and give Ready at E0+1 for every access.

Verification
REQ-032 Reset and LATENCY=2: write Address=0x10, MemDataIn=0xDEADBEEF at E0 -> Ready high during cycle E0+3, Error=0, and Busy high from E0+1 to E0+3.
REQ-033 Following REQ-032: Read Address=0x10 -> Mdatain=0xDEADBEEF and Ready at E0+3, and Mdatain held after Read drops.
REQ-034 Read held high for 6 cycles at Address=0x10 -> exactly one Ready pulse, with HOLD until Read drops, then IDLE.
REQ-035 Read=write=1 at Address=0x10 -> Ready=Error=1 for one cycle, and a later read of 0x10 still returns 0xDEADBEEF.
REQ-036 Read at Address=0x200 (DEPTH 512) -> Error=1, Mdatain=0x00000000; write 0x12345678 at 0x200 -> no array word changes.
REQ-037 Write 0x0000000F at 0x20, then GlobalReset pulsed low during WAIT -> Busy=0 immediately, and a read of 0x20 returns its prior value; with WAIT_STATES_EN undefined, any access -> Ready at E0+1.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory behind a Read/write handshake.
// Ports: Clock, GlobalReset (async, active-low); Read, write, Address and
// MemDataIn in; Mdatain, Ready, Busy and Error out.
// Define WAIT_STATES_EN to insert LATENCY wait cycles before each completion.
// Without it there is no WAIT state and no counter, and LATENCY is ignored.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clock,
  input  logic        GlobalReset,
  input  logic        Read,
  input  logic        write,
  input  logic [31:0] Address,
  input  logic [31:0] MemDataIn,
  output logic [31:0] Mdatain,
  output logic        Ready,
  output logic        Busy,
  output logic        Error
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef WAIT_STATES_EN
  typedef enum logic [1:0] {
    IDLE, WAIT, DONE, HOLD
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DONE, HOLD
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  logic [31:0] mem [DEPTH];

  logic        rd_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

`ifdef WAIT_STATES_EN
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
`endif

  logic        idle;
  logic        req;
  logic        accept;
  logic        enter_done;
  logic        s_rd;
  logic        s_wr;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_oor;
  logic        s_bad;
  logic [AW-1:0] s_idx;

  assign idle   = (state_q == IDLE);
  assign req    = Read | write;
  assign accept = idle & req;

  // With no wait cycles DONE is entered on the accepting
  // edge itself, so the access must use the live inputs;
  // later it uses the copy captured at acceptance.
  assign s_rd    = idle ? Read      : rd_q;
  assign s_wr    = idle ? write     : wr_q;
  assign s_addr  = idle ? Address   : addr_q;
  assign s_wdata = idle ? MemDataIn : wdata_q;

  assign s_oor = (s_addr >= DEPTH);
  assign s_bad = (s_rd & s_wr) | s_oor;
  assign s_idx = s_addr[AW-1:0];

  assign enter_done = (state_d == DONE) &&
                      (state_q != DONE);

  always_comb begin
    state_d = state_q;
`ifdef WAIT_STATES_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
`ifdef WAIT_STATES_EN
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
`ifdef WAIT_STATES_EN
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The array shares this block so that an edge seen
  // while reset is low can never commit a write; it has
  // no reset value of its own.
  always_ff @(posedge Clock or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q <= IDLE;
`ifdef WAIT_STATES_EN
      cnt_q   <= '0;
`endif
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      Mdatain <= '0;
    end else begin
      state_q <= state_d;
`ifdef WAIT_STATES_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        rd_q    <= Read;
        wr_q    <= write;
        addr_q  <= Address;
        wdata_q <= MemDataIn;
        err_q   <= (Read & write) |
                   (Address >= DEPTH);
      end
      if (enter_done) begin
        if (s_wr && !s_bad) begin
          mem[s_idx] <= s_wdata;
        end
        if (s_rd && !s_wr) begin
          Mdatain <= s_oor ? '0 : mem[s_idx];
        end
      end
    end
  end

  assign Ready = (state_q == DONE);
  assign Error = Ready & err_q;
  assign Busy  = ~idle;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table, reset-abort sequence and
// random transactions checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int unsigned DEPTH = 512;
`ifdef WAIT_STATES_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        Clock;
  logic        GlobalReset;
  logic        Read;
  logic        write;
  logic [31:0] Address;
  logic [31:0] MemDataIn;
  logic [31:0] Mdatain;
  logic        Ready;
  logic        Busy;
  logic        Error;

  mem_responder #(
    .DEPTH(DEPTH),
    .LATENCY(2)
  ) dut (
    .Clock(Clock),
    .GlobalReset(GlobalReset),
    .Read(Read),
    .write(write),
    .Address(Address),
    .MemDataIn(MemDataIn),
    .Mdatain(Mdatain),
    .Ready(Ready),
    .Busy(Busy),
    .Error(Error)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: memory contents known
  // to the bench and the value Mdatain should show.
  logic [31:0] mdl [int unsigned];
  logic [31:0] mdl_rd;
  bit          mdl_rd_known;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    bit          err;
    logic [31:0] rdv;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  // Computes the expected outcome of one access and
  // advances the reference model past it.
  task automatic model(input bit rd, input bit wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output bit eerr,
                       output logic [31:0] erd,
                       output bit crd);
    bit oor;
    oor  = (a >= DEPTH);
    eerr = (rd && wr) || oor;
    if (rd && !wr) begin
      if (oor) begin
        mdl_rd       = 32'h0;
        mdl_rd_known = 1'b1;
      end else if (mdl.exists(a)) begin
        mdl_rd       = mdl[a];
        mdl_rd_known = 1'b1;
      end else begin
        mdl_rd_known = 1'b0;
      end
    end else if (!eerr) begin
      mdl[a] = d;
    end
    erd = mdl_rd;
    crd = mdl_rd_known;
  endtask

  // Drives one access held for 'hold' edges and checks
  // Busy/Ready/Error after every edge until back in IDLE.
  task automatic run(input bit rd, input bit wr,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int hold,
                     input bit eerr,
                     input logic [31:0] erd,
                     input bit crd,
                     input string nm);
    int last;
    Read      = rd;
    write     = wr;
    Address   = a;
    MemDataIn = d;
    chk({nm, ".busy_pre"}, 32'(Busy), 32'h0);
    last = ((LAT > hold - 1) ? LAT : hold - 1) + 1;
    for (int k = 0; k <= last; k++) begin
      @(posedge Clock);
      #1;
      chk({nm, ".busy"}, 32'(Busy),
          32'((k <= LAT) || (k < hold)));
      chk({nm, ".ready"}, 32'(Ready),
          32'(k == LAT));
      chk({nm, ".error"}, 32'(Error),
          32'((k == LAT) && eerr));
      if (k == LAT && crd)
        chk({nm, ".rdata"}, Mdatain, erd);
      Address   = ~a;
      MemDataIn = $urandom;
      if (k == hold - 1) begin
        Read  = 1'b0;
        write = 1'b0;
      end
    end
    if (crd)
      chk({nm, ".rdata_held"}, Mdatain, erd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          eerr;
    logic [31:0] erd;
    bit          crd;
    logic [31:0] a;
    bit          rd;
    bit          wr;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h10,  32'h0,        6, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b1, 32'h10,  32'h11111111, 1, 1'b1, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,   32'hA5A5A5A5, 1, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,        1, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h200, 32'h12345678, 1, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1, 1'b0, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 1'b1, 32'h1FF, 32'hCAFEF00D, 3, 1'b0, 32'hA5A5A5A5};
    tbl[10] = '{1'b1, 1'b0, 32'h1FF, 32'h0,        1, 1'b0, 32'hCAFEF00D};
    tbl[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,   1, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 32'h20,  32'h00000077, 1, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h10,  32'h0,        1, 1'b0, 32'hDEADBEEF};

    Read        = 1'b0;
    write       = 1'b0;
    Address     = '0;
    MemDataIn   = '0;
    GlobalReset = 1'b1;
    #1 GlobalReset = 1'b0;
    #1;
    chk("rst_async.busy", 32'(Busy), 32'h0);
    chk("rst_async.ready", 32'(Ready), 32'h0);
    repeat (3) @(posedge Clock);
    #1;
    chk("rst.busy", 32'(Busy), 32'h0);
    chk("rst.ready", 32'(Ready), 32'h0);
    chk("rst.error", 32'(Error), 32'h0);
    chk("rst.rdata", Mdatain, 32'h0);
    GlobalReset  = 1'b1;
    mdl_rd       = 32'h0;
    mdl_rd_known = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].addr,
            tbl[i].data, eerr, erd, crd);
      run(tbl[i].rd, tbl[i].wr, tbl[i].addr,
          tbl[i].data, tbl[i].hold, tbl[i].err,
          tbl[i].rdv, 1'b1, $sformatf("vec%0d", i));
    end

    // Reset one edge after accepting a write to 0x20:
    // with wait states the write is still pending and
    // must be lost; without them it has already landed.
    Read      = 1'b0;
    write     = 1'b1;
    Address   = 32'h20;
    MemDataIn = 32'h0000000F;
    @(posedge Clock);
    #1;
    write = 1'b0;
    #1 GlobalReset = 1'b0;
    #1;
    chk("abort.busy", 32'(Busy), 32'h0);
    chk("abort.ready", 32'(Ready), 32'h0);
    chk("abort.error", 32'(Error), 32'h0);
    chk("abort.rdata", Mdatain, 32'h0);
    @(posedge Clock);
    #1 GlobalReset = 1'b1;
    mdl_rd       = 32'h0;
    mdl_rd_known = 1'b1;
    if (LAT == 0)
      mdl[32'h20] = 32'h0000000F;
    model(1'b1, 1'b0, 32'h20, 32'h0, eerr, erd, crd);
    run(1'b1, 1'b0, 32'h20, 32'h0, 1,
        eerr, erd, crd, "abort_read");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        2: begin rd = 1'b1; wr = 1'b0; end
        default: begin
          rd = 1'b1;
          wr = ($urandom_range(0, 1) == 1);
        end
      endcase
      case ($urandom_range(0, 7))
        0: a = 32'h200 + 32'($urandom_range(0, 3));
        1: a = 32'h1FF;
        default: a = 32'($urandom_range(0, 15));
      endcase
      MemDataIn = $urandom;
      model(rd, wr, a, MemDataIn, eerr, erd, crd);
      run(rd, wr, a, MemDataIn,
          $urandom_range(1, 4), eerr, erd, crd,
          $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
